inst_prefetch_queue: RTL

INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

---
 rtl/inst_prefetch_queue_if.sv | 30 +++
 rtl/inst_prefetch_queue.sv | 73 +++++++
 2 files changed

// File: rtl/inst_prefetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction prefetch queue.
// The queue uses the slave modport; the fetch/decode side uses master.
interface inst_prefetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic            fetch_valid;
  logic [31:0]     fetch_inst;
  logic [31:0]     fetch_pc4;
  logic            fetch_ready;
  logic            deco_ready;
  logic            deco_valid;
  logic [31:0]     deco_inst;
  logic [31:0]     deco_pc4;
  logic            flush;
  logic [CNTW-1:0] count;
  logic [CW-1:0]   flush_cnt;

  modport slave (
    input  fetch_valid, fetch_inst, fetch_pc4, deco_ready, flush,
    output fetch_ready, deco_valid, deco_inst, deco_pc4, count, flush_cnt
  );

  modport master (
    output fetch_valid, fetch_inst, fetch_pc4, deco_ready, flush,
    input  fetch_ready, deco_valid, deco_inst, deco_pc4, count, flush_cnt
  );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Circular instruction prefetch FIFO between fetch and decode, with flush on
// taken branch and a saturating counter of flushes that discarded entries.
module inst_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  inst_prefetch_queue_if.slave  q
);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [CW-1:0]   flush_cnt_q, flush_cnt_d;
  logic [63:0]     mem_q [DEPTH];
  logic            push, pop;

  // Outputs are combinational from state so an async reset is visible at once.
  always_comb begin
    q.fetch_ready = (count_q < CNTW'(DEPTH));
    q.deco_valid  = (count_q != '0);
    q.deco_inst   = q.deco_valid ? mem_q[rd_ptr_q][31:0]  : '0;
    q.deco_pc4    = q.deco_valid ? mem_q[rd_ptr_q][63:32] : '0;
    q.count       = count_q;
    q.flush_cnt   = flush_cnt_q;
  end

  always_comb begin
    push        = q.fetch_valid && q.fetch_ready && !q.flush;
    pop         = q.deco_valid  && q.deco_ready  && !q.flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    flush_cnt_d = flush_cnt_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if (count_q != '0 && flush_cnt_q != '1) begin
        flush_cnt_d = flush_cnt_q + CW'(1);
      end
    end else begin
      // Power-of-two depth: pointer wrap falls out of natural overflow.
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Storage is not reset; validity is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {q.fetch_pc4, q.fetch_inst};
    end
  end
endmodule
